// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage.
// Captures the memory-stage result each cycle, selects the register-file write
// data, exposes a forwarding source for execute, and keeps the cycle and
// retired-instruction counters.
module mem_wb_stage #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned COUNTER_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,

  // Memory-stage handoff
  input  logic                     valid_in,
  input  logic                     stall_in,
  input  logic                     flush_in,
  input  logic [DATA_WIDTH-1:0]    alu_data_in,
  input  logic [DATA_WIDTH-1:0]    memory_data_in,
  input  logic [DATA_WIDTH-1:0]    pc_in,
  input  logic [4:0]               rd_in,
  input  logic                     reg_write_in,
  input  logic [1:0]               wb_sel_in,

  // Register-file write port and forwarding source
  output logic                     reg_write_out,
  output logic [4:0]               wb_rd_out,
  output logic [DATA_WIDTH-1:0]    wb_data_out,
  output logic                     fwd_valid_out,

  // Retirement and performance counters
  output logic                     retire_out,
  output logic [COUNTER_WIDTH-1:0] cycle_count_out,
  output logic [COUNTER_WIDTH-1:0] instret_count_out
);

  // Writeback source encodings; 2'b11 is reserved and falls back to the ALU.
  localparam logic [1:0] WbSelAlu = 2'b00;
  localparam logic [1:0] WbSelMem = 2'b01;
  localparam logic [1:0] WbSelPc4 = 2'b10;

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic                     r_valid;
  // Set only on the cycle an instruction first lands here; cleared while the
  // stage holds, so side effects fire once per instruction.
  logic                     r_new;
  logic [DATA_WIDTH-1:0]    r_alu;
  logic [DATA_WIDTH-1:0]    r_mem;
  logic [DATA_WIDTH-1:0]    r_pc;
  logic [4:0]               r_rd;
  logic [1:0]               r_wb_sel;
  logic                     r_reg_write;

  logic [COUNTER_WIDTH-1:0] r_cycle;
  logic [COUNTER_WIDTH-1:0] r_instret;

  logic                     w_fwd_valid;
  logic                     w_retire;
  logic [DATA_WIDTH-1:0]    w_pc_plus4;
  logic [DATA_WIDTH-1:0]    w_wb_data;

  // Pipeline register: reset > flush > stall > capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid     <= 1'b0;
      r_new       <= 1'b0;
      r_alu       <= '0;
      r_mem       <= '0;
      r_pc        <= '0;
      r_rd        <= '0;
      r_wb_sel    <= '0;
      r_reg_write <= 1'b0;
    end else if (flush_in) begin
      // Payload fields are left alone; a bubble masks them.
      r_valid <= 1'b0;
      r_new   <= 1'b0;
    end else if (stall_in) begin
      r_new <= 1'b0;
    end else begin
      r_valid     <= valid_in;
      r_new       <= valid_in;
      r_alu       <= alu_data_in;
      r_mem       <= memory_data_in;
      r_pc        <= pc_in;
      r_rd        <= rd_in;
      r_wb_sel    <= wb_sel_in;
      r_reg_write <= reg_write_in;
    end
  end

  // Performance counters: free-running, wrap naturally, ignore stall/flush.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      r_cycle   <= r_cycle + COUNTER_WIDTH'(1);
      r_instret <= r_instret + COUNTER_WIDTH'(w_retire);
    end
  end

  // ---------------------------------------------------------------------------
  // Writeback datapath
  // ---------------------------------------------------------------------------
  // Link address for JAL/JALR; wraps modulo 2^DATA_WIDTH.
  assign w_pc_plus4 = r_pc + DATA_WIDTH'(4);

  // Writeback data select from the stored fields.
  always_comb begin
    w_wb_data = r_alu;
    case (r_wb_sel)
      WbSelAlu: w_wb_data = r_alu;
      WbSelMem: w_wb_data = r_mem;
      WbSelPc4: w_wb_data = w_pc_plus4;
      default:  w_wb_data = r_alu;
    endcase
  end

  // x0 is never a real destination, so it is neither forwarded nor written.
  assign w_fwd_valid = r_valid & r_reg_write & (r_rd != 5'd0);
  assign w_retire    = r_valid & r_new;

  assign reg_write_out     = w_fwd_valid & r_new;
  assign wb_rd_out         = r_rd;
  assign wb_data_out       = w_wb_data;
  assign fwd_valid_out     = w_fwd_valid;
  assign retire_out        = w_retire;
  assign cycle_count_out   = r_cycle;
  assign instret_count_out = r_instret;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: the stimulus thread pushes the expected
// writeback of every instruction it issues; a monitor pops and compares on
// each retire pulse. A second instance with 4-bit counters checks wrap.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_in, stall_in, flush_in;
  logic [31:0] alu_data_in, memory_data_in, pc_in;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic [1:0]  wb_sel_in;

  logic        reg_write_out, fwd_valid_out, retire_out;
  logic [4:0]  wb_rd_out;
  logic [31:0] wb_data_out;
  logic [63:0] cycle_count_out, instret_count_out;

  logic        w4_reg_write, w4_fwd_valid, w4_retire;
  logic [4:0]  w4_rd;
  logic [31:0] w4_data;
  logic [3:0]  w4_cycle, w4_instret;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_WIDTH(32), .COUNTER_WIDTH(64)) dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .stall_in(stall_in),
    .flush_in(flush_in), .alu_data_in(alu_data_in), .memory_data_in(memory_data_in),
    .pc_in(pc_in), .rd_in(rd_in), .reg_write_in(reg_write_in), .wb_sel_in(wb_sel_in),
    .reg_write_out(reg_write_out), .wb_rd_out(wb_rd_out), .wb_data_out(wb_data_out),
    .fwd_valid_out(fwd_valid_out), .retire_out(retire_out),
    .cycle_count_out(cycle_count_out), .instret_count_out(instret_count_out)
  );

  mem_wb_stage #(.DATA_WIDTH(32), .COUNTER_WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .stall_in(stall_in),
    .flush_in(flush_in), .alu_data_in(alu_data_in), .memory_data_in(memory_data_in),
    .pc_in(pc_in), .rd_in(rd_in), .reg_write_in(reg_write_in), .wb_sel_in(wb_sel_in),
    .reg_write_out(w4_reg_write), .wb_rd_out(w4_rd), .wb_data_out(w4_data),
    .fwd_valid_out(w4_fwd_valid), .retire_out(w4_retire),
    .cycle_count_out(w4_cycle), .instret_count_out(w4_instret)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_issued = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a cycle and record what it must write back.
  task automatic issue(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] pc, input logic [31:0] exp_data);
    exp_t e;
    valid_in       = 1'b1;
    stall_in       = 1'b0;
    flush_in       = 1'b0;
    reg_write_in   = rw;
    rd_in          = rd;
    wb_sel_in      = sel;
    alu_data_in    = alu;
    memory_data_in = mem;
    pc_in          = pc;
    e.rd   = rd;
    e.data = exp_data;
    e.we   = rw && (rd != 5'd0);
    sb.push_back(e);
    n_issued++;
    step();
  endtask

  task automatic idle();
    valid_in = 1'b0;
    stall_in = 1'b0;
    flush_in = 1'b0;
    step();
  endtask

  // Monitor: every retire pulse must match the oldest outstanding instruction.
  always @(negedge clk) begin
    if (retire_out) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_retire: got retire with rd=%0d, expected none", wb_rd_out);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_rd", 64'(wb_rd_out), 64'(mon_e.rd));
        chk("wb_data", 64'(wb_data_out), 64'(mon_e.data));
        chk("reg_write", 64'(reg_write_out), 64'(mon_e.we));
        chk("fwd_valid", 64'(fwd_valid_out), 64'(mon_e.we));
      end
    end else if (reg_write_out) begin
      chk("write_without_retire", 64'(reg_write_out), 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n        = 1'b0;
    valid_in       = 1'b1;
    stall_in       = 1'b0;
    flush_in       = 1'b0;
    reg_write_in   = 1'b1;
    rd_in          = 5'd3;
    wb_sel_in      = 2'b01;
    alu_data_in    = 32'h0;
    memory_data_in = 32'h0;
    pc_in          = 32'h0;

    // Reset held for two edges with random inputs.
    for (int i = 0; i < 2; i++) begin
      alu_data_in    = $urandom;
      memory_data_in = $urandom;
      pc_in          = $urandom;
      rd_in          = 5'($urandom_range(1, 31));
      wb_sel_in      = 2'($urandom_range(0, 3));
      step();
    end
    chk("rst_reg_write", 64'(reg_write_out), 64'd0);
    chk("rst_fwd_valid", 64'(fwd_valid_out), 64'd0);
    chk("rst_retire", 64'(retire_out), 64'd0);
    chk("rst_wb_rd", 64'(wb_rd_out), 64'd0);
    chk("rst_wb_data", 64'(wb_data_out), 64'd0);
    chk("rst_cycle", cycle_count_out, 64'd0);
    chk("rst_instret", instret_count_out, 64'd0);

    reset_n = 1'b1;
    idle();
    chk("cycle_after_release", cycle_count_out, 64'd1);

    // ALU writeback, then instret visible one cycle after the retire.
    issue(1'b1, 5'd5, 2'b00, 32'h1234_5678, 32'h0, 32'h0, 32'h1234_5678);
    idle();
    chk("instret_first", instret_count_out, 64'd1);

    // Back-to-back: load, JAL, JAL at top of memory, reserved select, x0, store.
    issue(1'b1, 5'd6, 2'b01, 32'h1111_1111, 32'hFFFF_FF80, 32'h0, 32'hFFFF_FF80);
    issue(1'b1, 5'd1, 2'b10, 32'h2222_2222, 32'h0, 32'h0000_0100, 32'h0000_0104);
    issue(1'b1, 5'd2, 2'b10, 32'h3333_3333, 32'h0, 32'hFFFF_FFFC, 32'h0000_0000);
    issue(1'b1, 5'd3, 2'b11, 32'h0000_A5A5, 32'h5A5A_0000, 32'h40, 32'h0000_A5A5);
    issue(1'b1, 5'd0, 2'b00, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'hDEAD_BEEF);
    issue(1'b0, 5'd9, 2'b00, 32'h0000_0999, 32'h0, 32'h0, 32'h0000_0999);
    idle();
    chk("instret_after_burst", instret_count_out, 64'(n_issued));

    // Stall: one write/retire, then three held cycles with the same data.
    issue(1'b1, 5'd7, 2'b00, 32'h0000_0077, 32'h0, 32'h0, 32'h0000_0077);
    chk("stall0_fwd", 64'(fwd_valid_out), 64'd1);
    chk("stall0_data", 64'(wb_data_out), 64'h77);
    valid_in     = 1'b1;
    stall_in     = 1'b1;
    rd_in        = 5'd8;
    alu_data_in  = 32'h0000_0BAD;
    reg_write_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_reg_write", 64'(reg_write_out), 64'd0);
      chk("stall_retire", 64'(retire_out), 64'd0);
      chk("stall_fwd", 64'(fwd_valid_out), 64'd1);
      chk("stall_data", 64'(wb_data_out), 64'h77);
      chk("stall_rd", 64'(wb_rd_out), 64'd7);
    end
    idle();
    chk("instret_after_stall", instret_count_out, 64'(n_issued));

    // Flush wins over a simultaneous stall; the valid instruction becomes a bubble.
    valid_in     = 1'b1;
    flush_in     = 1'b1;
    stall_in     = 1'b1;
    rd_in        = 5'd10;
    reg_write_in = 1'b1;
    alu_data_in  = 32'h0000_1010;
    step();
    chk("flush_fwd", 64'(fwd_valid_out), 64'd0);
    chk("flush_retire", 64'(retire_out), 64'd0);
    chk("flush_reg_write", 64'(reg_write_out), 64'd0);
    idle();
    chk("instret_after_flush", instret_count_out, 64'(n_issued));

    // Reset during a stall clears everything.
    issue(1'b1, 5'd11, 2'b00, 32'h0000_0011, 32'h0, 32'h0, 32'h0000_0011);
    reset_n  = 1'b0;
    stall_in = 1'b1;
    valid_in = 1'b1;
    step();
    chk("rst_stall_fwd", 64'(fwd_valid_out), 64'd0);
    chk("rst_stall_retire", 64'(retire_out), 64'd0);
    chk("rst_stall_data", 64'(wb_data_out), 64'd0);
    chk("rst_stall_rd", 64'(wb_rd_out), 64'd0);
    chk("rst_stall_cycle", cycle_count_out, 64'd0);
    chk("rst_stall_instret", instret_count_out, 64'd0);
    chk("rst_stall_cycle4", 64'(w4_cycle), 64'd0);

    // Counter wrap on the 4-bit instance.
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) idle();
    chk("cycle4_at_15", 64'(w4_cycle), 64'd15);
    idle();
    chk("cycle4_wrap", 64'(w4_cycle), 64'd0);
    chk("cycle_at_16", cycle_count_out, 64'd16);
    chk("instret_idle", instret_count_out, 64'd0);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
